// File: rtl/pd_seq_pkg.sv
// Shared definitions for the power-domain switch sequencer: state encodings
// and the per-state control output decode.
package pd_seq_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_OFF     = 3'd0,
    ST_PWR_UP  = 3'd1,
    ST_RESTORE = 3'd2,
    ST_DEISO   = 3'd3,
    ST_ON      = 3'd4,
    ST_ISO     = 3'd5,
    ST_SAVE    = 3'd6,
    ST_PWR_DN  = 3'd7
  } state_e;

  typedef struct packed {
    logic iso_en;
    logic sw_en;
    logic save;
    logic restore;
    logic pwr_ack;
  } seq_out_t;

  localparam seq_out_t OUT_OFF     = '{iso_en: 1'b1, sw_en: 1'b0, save: 1'b0, restore: 1'b0, pwr_ack: 1'b0};
  localparam seq_out_t OUT_PWR_UP  = '{iso_en: 1'b1, sw_en: 1'b1, save: 1'b0, restore: 1'b0, pwr_ack: 1'b0};
  localparam seq_out_t OUT_RESTORE = '{iso_en: 1'b1, sw_en: 1'b1, save: 1'b0, restore: 1'b1, pwr_ack: 1'b0};
  localparam seq_out_t OUT_DEISO   = '{iso_en: 1'b0, sw_en: 1'b1, save: 1'b0, restore: 1'b0, pwr_ack: 1'b0};
  localparam seq_out_t OUT_ON      = '{iso_en: 1'b0, sw_en: 1'b1, save: 1'b0, restore: 1'b0, pwr_ack: 1'b1};
  localparam seq_out_t OUT_ISO     = '{iso_en: 1'b1, sw_en: 1'b1, save: 1'b0, restore: 1'b0, pwr_ack: 1'b0};
  localparam seq_out_t OUT_SAVE    = '{iso_en: 1'b1, sw_en: 1'b1, save: 1'b1, restore: 1'b0, pwr_ack: 1'b0};
  localparam seq_out_t OUT_PWR_DN  = '{iso_en: 1'b1, sw_en: 1'b0, save: 1'b0, restore: 1'b0, pwr_ack: 1'b0};

  function automatic seq_out_t decode_out(input state_e st);
    seq_out_t o;
    o = OUT_OFF;
    case (st)
      ST_OFF:     o = OUT_OFF;
      ST_PWR_UP:  o = OUT_PWR_UP;
      ST_RESTORE: o = OUT_RESTORE;
      ST_DEISO:   o = OUT_DEISO;
      ST_ON:      o = OUT_ON;
      ST_ISO:     o = OUT_ISO;
      ST_SAVE:    o = OUT_SAVE;
      ST_PWR_DN:  o = OUT_PWR_DN;
      default:    o = OUT_OFF;
    endcase
    return o;
  endfunction

  function automatic logic is_busy(input state_e st);
    return !((st == ST_OFF) || (st == ST_ON));
  endfunction

endpackage

// File: rtl/pd_seq_timer.sv
// Load/decrement wait timer shared by all timed sequencer states; saturates
// at zero and flags terminal count with a registered zero.
module pd_seq_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero_q, zero_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    zero_d = (cnt_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= zero_d;
    end
  end

  assign zero = zero_q;

endmodule

// File: rtl/pd_switch_sequencer.sv
// Power-gating sequencer for one switchable domain: orders isolate/save/
// switch-off and switch-on/restore/de-isolate, with a sticky switch timeout.
module pd_switch_sequencer
  import pd_seq_pkg::*;
#(
  parameter int unsigned SAVE_CYCLES    = 2,
  parameter int unsigned RESTORE_CYCLES = 2,
  parameter int unsigned SW_TIMEOUT     = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pwr_on_req,
  input  logic               pwr_good,
  input  logic               err_clr,
  output logic               pwr_ack,
  output logic               busy,
  output logic               iso_en,
  output logic               sw_en,
  output logic               save,
  output logic               restore,
  output logic               err,
  output logic [STATE_W-1:0] state
);

  state_e     state_q, state_d;
  seq_out_t   out_q, out_d;
  logic       busy_q, busy_d;
  logic       err_q, err_d;
  logic       timeout_c;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_zero;

  pd_seq_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Next-state logic; timeouts abandon the sequence and land in OFF.
  always_comb begin
    state_d   = state_q;
    timeout_c = 1'b0;
    unique case (state_q)
      ST_OFF: begin
        if (pwr_on_req && !err_q) state_d = ST_PWR_UP;
      end
      ST_PWR_UP: begin
        if (pwr_good) begin
          state_d = ST_RESTORE;
        end else if (tmr_zero) begin
          timeout_c = 1'b1;
          state_d   = ST_OFF;
        end
      end
      ST_RESTORE: begin
        if (tmr_zero) state_d = ST_DEISO;
      end
      ST_DEISO: begin
        state_d = ST_ON;
      end
      ST_ON: begin
        if (!pwr_on_req) state_d = ST_ISO;
      end
      ST_ISO: begin
        state_d = ST_SAVE;
      end
      ST_SAVE: begin
        if (tmr_zero) state_d = ST_PWR_DN;
      end
      ST_PWR_DN: begin
        if (!pwr_good) begin
          state_d = ST_OFF;
        end else if (tmr_zero) begin
          timeout_c = 1'b1;
          state_d   = ST_OFF;
        end
      end
      default: begin
        state_d = ST_OFF;
      end
    endcase
  end

  // Timer reload on every state change; count is cycles-in-state minus one.
  always_comb begin
    tmr_load = (state_d != state_q);
    tmr_val  = '0;
    case (state_d)
      ST_PWR_UP,
      ST_PWR_DN:  tmr_val = CNT_W'(SW_TIMEOUT - 1);
      ST_RESTORE: tmr_val = CNT_W'(RESTORE_CYCLES - 1);
      ST_SAVE:    tmr_val = CNT_W'(SAVE_CYCLES - 1);
      default:    tmr_val = '0;
    endcase
  end

  // Outputs decoded from the next state so they are valid on state entry.
  always_comb begin
    out_d  = decode_out(state_d);
    busy_d = is_busy(state_d);
    err_d  = err_q;
    if (err_clr)   err_d = 1'b0;
    if (timeout_c) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_OFF;
      out_q   <= OUT_OFF;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign pwr_ack = out_q.pwr_ack;
  assign iso_en  = out_q.iso_en;
  assign sw_en   = out_q.sw_en;
  assign save    = out_q.save;
  assign restore = out_q.restore;
  assign busy    = busy_q;
  assign err     = err_q;
  assign state   = state_q;

endmodule

// File: tb/tb_pd_switch_sequencer.sv
// Bench for pd_switch_sequencer: directed sequences plus randomized requests
// and switch latencies, checked every cycle against a cycle-count reference.
module tb_pd_switch_sequencer;

  localparam int unsigned SAVE_N = 2;
  localparam int unsigned REST_N = 2;
  localparam int unsigned TMO_N  = 5;

  // Expected {iso_en, sw_en, save, restore, pwr_ack} indexed by state code.
  localparam bit [4:0] OUT_TAB [8] = '{
    5'b10000, 5'b11000, 5'b11010, 5'b01000,
    5'b01001, 5'b11000, 5'b11100, 5'b10000
  };

  logic       clk = 1'b0;
  logic       rst;
  logic       pwr_on_req;
  logic       pwr_good;
  logic       err_clr;
  logic       pwr_ack;
  logic       busy;
  logic       iso_en;
  logic       sw_en;
  logic       save;
  logic       restore;
  logic       err;
  logic [2:0] state;

  always #5 clk = ~clk;

  pd_switch_sequencer #(
    .SAVE_CYCLES    (SAVE_N),
    .RESTORE_CYCLES (REST_N),
    .SW_TIMEOUT     (TMO_N),
    .CNT_W          (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pwr_on_req (pwr_on_req),
    .pwr_good   (pwr_good),
    .err_clr    (err_clr),
    .pwr_ack    (pwr_ack),
    .busy       (busy),
    .iso_en     (iso_en),
    .sw_en      (sw_en),
    .save       (save),
    .restore    (restore),
    .err        (err),
    .state      (state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference: state code plus number of edges spent in it so far.
  int unsigned m_st  = 0;
  int unsigned m_age = 0;
  bit          m_err = 1'b0;

  task automatic model_reset();
    m_st  = 0;
    m_age = 0;
    m_err = 1'b0;
  endtask

  task automatic model_step();
    int unsigned nxt = m_st;
    int unsigned k   = m_age + 1;
    bit          tmo = 1'b0;
    case (m_st)
      0: if (pwr_on_req && !m_err) nxt = 1;
      1: begin
        if (pwr_good) nxt = 2;
        else if (k >= TMO_N) begin nxt = 0; tmo = 1'b1; end
      end
      2: if (k >= REST_N) nxt = 3;
      3: nxt = 4;
      4: if (!pwr_on_req) nxt = 5;
      5: nxt = 6;
      6: if (k >= SAVE_N) nxt = 7;
      7: begin
        if (!pwr_good) nxt = 0;
        else if (k >= TMO_N) begin nxt = 0; tmo = 1'b1; end
      end
      default: nxt = 0;
    endcase
    if (err_clr) m_err = 1'b0;
    if (tmo)     m_err = 1'b1;
    m_age = (nxt != m_st) ? 0 : k;
    m_st  = nxt;
  endtask

  task automatic check_outs();
    bit [4:0] e;
    e = OUT_TAB[3'(m_st)];
    chk("state",   32'(state),   32'(m_st));
    chk("iso_en",  32'(iso_en),  32'(e[4]));
    chk("sw_en",   32'(sw_en),   32'(e[3]));
    chk("save",    32'(save),    32'(e[2]));
    chk("restore", 32'(restore), 32'(e[1]));
    chk("pwr_ack", 32'(pwr_ack), 32'(e[0]));
    chk("busy",    32'(busy),    32'(m_st != 0 && m_st != 4));
    chk("err",     32'(err),     32'(m_err));
  endtask

  // Switch model: pwr_good follows the expected sw_en after lag cycles.
  int unsigned lag      = 0;
  int unsigned lag_cnt  = 0;
  bit          rand_lag = 1'b0;
  bit          prev_sw  = 1'b0;

  task automatic drive_pg();
    bit [4:0] e;
    bit       sw;
    e  = OUT_TAB[3'(m_st)];
    sw = e[3];
    if (sw != prev_sw) begin
      if (rand_lag) lag = ($urandom_range(0, 9) == 0) ? 7 : $urandom_range(0, 3);
      lag_cnt = lag;
    end
    prev_sw = sw;
    if (pwr_good != sw) begin
      if (lag_cnt == 0) pwr_good = sw;
      else lag_cnt--;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    @(negedge clk);
    check_outs();
    drive_pg();
  endtask

  initial begin
    int ack_e, r_cnt, r_fall, iso_fall, s_cnt, sw_fall, off_e, err_e;
    bit r_prev, i_prev, sw_prev, seen_on;

    rst        = 1'b1;
    pwr_on_req = 1'b0;
    pwr_good   = 1'b0;
    err_clr    = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_state",  32'(state),   32'd0);
    chk("rst_iso_en", 32'(iso_en),  32'd1);
    chk("rst_sw_en",  32'(sw_en),   32'd0);
    chk("rst_ack",    32'(pwr_ack), 32'd0);
    chk("rst_busy",   32'(busy),    32'd0);
    chk("rst_err",    32'(err),     32'd0);
    rst = 1'b0;
    repeat (3) tick();
    chk("idle_state", 32'(state), 32'd0);

    // Power-up with the switch 3 cycles late.
    lag = 3; pwr_on_req = 1'b1;
    ack_e = -1; r_cnt = 0; r_fall = -1; iso_fall = -1; r_prev = 1'b0; i_prev = 1'b1;
    for (int i = 0; i < 30 && ack_e < 0; i++) begin
      tick();
      if (restore) r_cnt++;
      if (r_prev && !restore && r_fall < 0) r_fall = i;
      if (i_prev && !iso_en && iso_fall < 0) iso_fall = i;
      r_prev = restore;
      i_prev = iso_en;
      if (pwr_ack) ack_e = i;
    end
    chk("up_ack_edge",     32'(ack_e),    32'd7);
    chk("up_restore_len",  32'(r_cnt),    32'd2);
    chk("up_restore_fall", 32'(r_fall),   32'd6);
    chk("up_iso_fall",     32'(iso_fall), 32'd6);

    // Power-down with the switch releasing right after sw_en drops.
    lag = 0; pwr_on_req = 1'b0;
    s_cnt = 0; sw_fall = -1; off_e = -1; sw_prev = 1'b1;
    for (int i = 0; i < 30 && off_e < 0; i++) begin
      tick();
      if (i == 0) chk("dn_ack_drop", 32'(pwr_ack), 32'd0);
      if (save) s_cnt++;
      if (sw_prev && !sw_en && sw_fall < 0) sw_fall = i;
      sw_prev = sw_en;
      if (state == 3'd0) off_e = i;
    end
    chk("dn_save_len", 32'(s_cnt),   32'd2);
    chk("dn_sw_fall",  32'(sw_fall), 32'd3);
    chk("dn_off_edge", 32'(off_e),   32'd4);

    // Switch never comes up: timeout, sticky err, then clear and retry.
    lag = 99; pwr_on_req = 1'b1; err_e = -1;
    for (int i = 0; i < 20 && err_e < 0; i++) begin
      tick();
      if (err) err_e = i;
    end
    chk("tmo_err_edge", 32'(err_e), 32'd5);
    chk("tmo_off",      32'(state), 32'd0);
    repeat (4) tick();
    chk("tmo_hold_off", 32'(state), 32'd0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("tmo_cleared",  32'(err),   32'd0);
    chk("tmo_clr_off",  32'(state), 32'd0);
    lag = 0;
    tick();
    chk("tmo_restart",  32'(state), 32'd1);
    for (int i = 0; i < 20 && state != 3'd4; i++) tick();
    chk("tmo_reach_on", 32'(state), 32'd4);

    // Request dropped during RESTORE: finish up, then go straight down.
    pwr_on_req = 1'b0;
    for (int i = 0; i < 30 && state != 3'd0; i++) tick();
    pwr_on_req = 1'b1;
    for (int i = 0; i < 30 && state != 3'd2; i++) tick();
    pwr_on_req = 1'b0;
    seen_on = 1'b0;
    for (int i = 0; i < 10 && !seen_on; i++) begin
      tick();
      if (state == 3'd4) seen_on = 1'b1;
    end
    chk("tog_reach_on", 32'(seen_on), 32'd1);
    tick();
    chk("tog_then_iso", 32'(state), 32'd5);

    // Asynchronous reset in the middle of SAVE.
    tick();
    chk("save_entered", 32'(state), 32'd6);
    #2 rst = 1'b1;
    #1;
    chk("arst_state",  32'(state),  32'd0);
    chk("arst_iso_en", 32'(iso_en), 32'd1);
    chk("arst_sw_en",  32'(sw_en),  32'd0);
    chk("arst_save",   32'(save),   32'd0);
    tick();
    rst = 1'b0;

    // Randomized requests, clears, resets and switch latencies.
    rand_lag = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) pwr_on_req = ~pwr_on_req;
      err_clr = ($urandom_range(0, 15) == 0);
      rst     = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0; err_clr = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
